int2float_rr_scheduler: RTL and testbench
=========================================

// Module: int2float_rr_scheduler
// PURPOSE
//  Shares one int-to-float conversion datapath between N_REQ AXI-Stream integer producers.
//  - Round-robin arbitration; the granted integer is converted to IEEE-754 single precision.
//  - Results are buffered in an output FIFO and tagged with the source index on m_axis_tuser.
//  - Sits between the per-channel integer sources and the single float consumer (DSP/DMA path).
// PARAMETERS
//  N_REQ      4   number of requesters, 2..16
//  ID_W       2   tag width, = clog2(N_REQ), min 1
//  FIFO_DEPTH 4   output FIFO entries, power of 2, 2..16
// PORTS
//  aclk           in   1          clock, all logic on rising edge
//  areset         in   1          synchronous reset, active-high
//  s_axis_tdata   in   N_REQ*32   requester i int32 (2's complement) at [32*i+31:32*i]
//  s_axis_tvalid  in   N_REQ      requester i valid
//  s_axis_tready  out  N_REQ      requester i accepted this cycle
//  m_axis_tdata   out  32         float32 result {sign, exp[7:0], mant[22:0]}
//  m_axis_tuser   out  ID_W       index of the requester that produced the result
//  m_axis_tvalid  out  1          FIFO head valid
//  m_axis_tready  in   1          consumer ready
//  fifo_level     out  clog2(FIFO_DEPTH)+1   FIFO entries currently held
// BEHAVIOUR
//  Reset (areset=1 at edge): rr_ptr=0, s1_valid=0, FIFO empty, m_axis_tvalid=0, s_axis_tready=0,
//   fifo_level=0, m_axis_tdata/tuser=0. In-flight S1 data is dropped. Unpopped FIFO data is dropped.
//  Credit: issue_ok = (fifo_level + s1_valid) < FIFO_DEPTH. A pop in the same cycle earns no credit.
//  Arbitration, combinational: search tvalid from rr_ptr upward, modulo N_REQ.
//   - The first set bit wins when issue_ok.
//   - s_axis_tready is one-hot on the winner, and all zero when there is no winner or !issue_ok.
//   - tready does not depend on m_axis_tready.
//  On a handshake: rr_ptr <= (winner+1) mod N_REQ. Otherwise rr_ptr holds.
//  S1 register: on a handshake it captures {winner id, int32} and sets s1_valid=1.
//   Without a handshake, s1_valid <= 0.
//  Convert, combinational on S1:
//   - Zero -> 0x00000000.
//   - Otherwise sign=bit31 and abs = 2's-complement magnitude, as a 32-bit unsigned value.
//     0x80000000 gives abs=2^31.
//   - p = index of the leading one. exp = 127 + p.
//   - mant = bits below the leading one, left-aligned to 23 bits. Truncate toward zero, no rounding.
//  FIFO push: when s1_valid, push {id, float}. The credit rule guarantees no push on a full FIFO.
//  FIFO pop: when m_axis_tvalid && m_axis_tready.
//   - Simultaneous push and pop leaves the level unchanged.
//   - Pop on empty cannot occur.
//  Latency: s handshake at edge k -> S1 valid after k -> FIFO entry after k+1.
//   - m_axis_tvalid is high in cycle k+2 if the FIFO was empty. Throughput 1/cycle while credit allows.
//  m_axis_* is driven from the FIFO head register and holds stable while tvalid && !tready.
//  Order: results leave in grant order. The source tag always matches the data.
//  tvalid dropping without a handshake is tolerated: that input is simply not granted.
// STRUCTURE
//  Package int2float_pkg:
//   - F32_BIAS=127, F32_EXP_W=8, F32_MANT_W=23, INT_W=32.
//   - f32_t packed struct {sign, exp, mant}.
//  Sub-module int_to_float_core: purely combinational int32 -> f32_t, with the rules above.
//  Top: RR arbiter, rr_ptr, S1 register, and a circular FIFO with wr/rd pointers (wrap at FIFO_DEPTH)
//   plus a level counter.
// TESTING
//  1. Single source 0: ints 1, -1, 0, 0x80000000, 16777217.
//     -> 0x3F800000, 0xBF800000, 0x00000000, 0xCF000000, 0x4B800000; tuser=0; first out 2 cycles after handshake.
//  2. All 4 tvalid held high, m_axis_tready=1 -> grants 0,1,2,3,0,1,...
//     One accept per cycle; tuser sequence matches the grants.
//  3. m_axis_tready=0 with all sources valid -> exactly FIFO_DEPTH=4 accepts, then tready=0.
//     fifo_level=4, m_axis_tdata stable. Release -> 4 in-order pops, then accepts resume.
//  4. Only sources 1 and 3 valid, rr_ptr=2 -> 3 wins, then 1, then 3 (rr_ptr wraps 3->0).
//  5. areset asserted with S1 valid and 3 FIFO entries -> next cycle: tvalid=0, level=0,
//     all tready=0 during reset, rr_ptr=0 (source 0 wins first afterwards).
//  6. Random valids, random tready, 10k cycles vs reference model.
//     -> no loss, no duplication, per-source order kept, tuser/data consistent.

Source files
------------

// File: rtl/int2float_pkg.sv
// Shared types and constants for the int32 -> float32 scheduler.
package int2float_pkg;

    localparam int F32_BIAS   = 127;
    localparam int F32_EXP_W  = 8;
    localparam int F32_MANT_W = 23;
    localparam int INT_W      = 32;

    // IEEE-754 single precision, MSB first so the packed value is the raw bit pattern.
    typedef struct packed {
        logic                  sign;
        logic [F32_EXP_W-1:0]  exp;
        logic [F32_MANT_W-1:0] mant;
    } f32_t;

endpackage

// File: rtl/int_to_float_core.sv
// Combinational int32 (two's complement) to float32 conversion.
// Mantissa is truncated toward zero; there is no rounding and no denormal path
// (every nonzero int32 is exactly representable in exponent range).
module int_to_float_core
    import int2float_pkg::*;
(
    input  logic [INT_W-1:0] int_i,
    output f32_t             flt_o
);

    logic             sign;
    logic [INT_W-1:0] mag;
    logic [4:0]       lead;

    // Magnitude, leading-one position and field packing.
    always_comb begin
        sign  = int_i[INT_W-1];
        // 0x80000000 negates to itself, which read as unsigned is exactly 2^31.
        mag   = sign ? (~int_i + 32'd1) : int_i;
        lead  = 5'd0;
        for (int i = 0; i < INT_W; i++) begin
            if (mag[i]) begin
                lead = 5'(i);
            end
        end
        flt_o = '0;
        if (mag != '0) begin
            flt_o.sign = sign;
            flt_o.exp  = 8'(F32_BIAS) + {3'b000, lead};
            // Move the leading one to bit 31; bits 30..8 then form the mantissa and the
            // cast drops the implicit one.
            flt_o.mant = 23'((mag << (5'd31 - lead)) >> 8);
        end
    end

endmodule

// File: rtl/int2float_rr_scheduler.sv
// Round-robin scheduler sharing one int32 -> float32 converter between N_REQ
// AXI-Stream producers. Results are queued in an output FIFO and tagged with
// the producing requester index on m_axis_tuser.
//
// Handshake semantics (both ports): a transfer happens on a rising edge where
// tvalid && tready are both high; a producer may drop tvalid without a transfer,
// in which case it is simply not granted. s_axis_tready is one-hot on the
// arbitration winner, depends only on tvalid, internal state and areset, and never
// on m_axis_tready.
module int2float_rr_scheduler
    import int2float_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int ID_W       = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [N_REQ*INT_W-1:0]      s_axis_tdata,
    input  logic [N_REQ-1:0]            s_axis_tvalid,
    output logic [N_REQ-1:0]            s_axis_tready,
    output logic [INT_W-1:0]            m_axis_tdata,
    output logic [ID_W-1:0]             m_axis_tuser,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef struct packed {
        logic [ID_W-1:0] id;
        f32_t            flt;
    } fifo_entry_t;

    // Arbitration state and S1 register
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic             s1_valid_q;
    logic [ID_W-1:0]  s1_id_q;
    logic [INT_W-1:0] s1_data_q;
    f32_t             s1_flt;

    // Output FIFO
    fifo_entry_t      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    fifo_entry_t      head;

    // Arbiter signals
    logic             issue_ok;
    logic             hi_found, lo_found;
    logic [ID_W-1:0]  hi_id, lo_id;
    logic [ID_W-1:0]  winner;
    logic             grant;
    logic [INT_W-1:0] win_data;
    logic             push, pop;

    // Credit: entries already in the FIFO plus the one in S1 must leave room.
    // A pop in the same cycle is deliberately not counted as freed space.
    assign issue_ok = (int'(level_q) + int'(s1_valid_q)) < FIFO_DEPTH;

    // Round-robin search: first valid at or above rr_ptr, else the lowest valid overall.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_id    = '0;
        lo_id    = '0;
        // Descending scan so the last hit is the lowest index in each class.
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (s_axis_tvalid[ID_W'(j)]) begin
                lo_found = 1'b1;
                lo_id    = ID_W'(j);
                if (j >= int'(rr_ptr_q)) begin
                    hi_found = 1'b1;
                    hi_id    = ID_W'(j);
                end
            end
        end
        winner = hi_found ? hi_id : lo_id;
        grant  = lo_found && issue_ok && !areset;
    end

    // One-hot ready on the winner and data select for the S1 capture.
    always_comb begin
        s_axis_tready = '0;
        win_data      = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (ID_W'(j) == winner) begin
                s_axis_tready[j] = grant;
                win_data         = s_axis_tdata[j*INT_W +: INT_W];
            end
        end
    end

    // Pointer advances past the winner only when a transfer actually happens.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant) begin
            rr_ptr_d = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + ID_W'(1);
        end
    end

    // S1 register: holds the granted integer for one cycle while it is converted.
    always_ff @(posedge aclk) begin
        if (areset) begin
            rr_ptr_q   <= '0;
            s1_valid_q <= 1'b0;
            s1_id_q    <= '0;
            s1_data_q  <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            s1_valid_q <= grant;
            if (grant) begin
                s1_id_q   <= winner;
                s1_data_q <= win_data;
            end
        end
    end

    int_to_float_core u_core (
        .int_i (s1_data_q),
        .flt_o (s1_flt)
    );

    assign push = s1_valid_q;
    assign pop  = m_axis_tvalid && m_axis_tready;

    // FIFO pointers and level; pointers wrap naturally since FIFO_DEPTH is a power of 2.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // FIFO storage; contents need no reset because the level gates visibility.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{id: s1_id_q, flt: s1_flt};
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign m_axis_tvalid = (level_q != '0);
    assign m_axis_tdata  = m_axis_tvalid ? head.flt : '0;
    assign m_axis_tuser  = m_axis_tvalid ? head.id  : '0;
    assign fifo_level    = level_q;

endmodule

// File: tb/tb_int2float_rr_scheduler.sv
// Bench for int2float_rr_scheduler: directed scenarios plus a long random run,
// all outputs checked against an independent arbitration / conversion model.
module tb_int2float_rr_scheduler;

    localparam int N_REQ      = 4;
    localparam int ID_W       = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int W          = ID_W + 32;

    // ---------------- clock / reset ----------------
    logic clk;
    logic areset;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [N_REQ*32-1:0] s_tdata;
    logic [N_REQ-1:0]    s_tvalid;
    logic [N_REQ-1:0]    s_tready;
    logic [31:0]         m_tdata;
    logic [ID_W-1:0]     m_tuser;
    logic                m_tvalid;
    logic                m_tready;
    logic [2:0]          fifo_level;

    int2float_rr_scheduler #(
        .N_REQ      (N_REQ),
        .ID_W       (ID_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .aclk          (clk),
        .areset        (areset),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tuser  (m_tuser),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .fifo_level    (fifo_level)
    );

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference conversion: normalise by shifting until bit 31 is set.
    function automatic logic [31:0] ref_f32(input logic [31:0] x);
        logic        s;
        logic [31:0] m;
        int          e;
        if (x == 32'd0) return 32'd0;
        s = x[31];
        m = s ? (~x + 32'd1) : x;
        e = 158;
        while (!m[31]) begin
            m = m << 1;
            e--;
        end
        return {s, e[7:0], m[30:8]};
    endfunction

    // ---------------- scoreboard / model ----------------
    logic [W-1:0] exp_q[$];
    logic         mon_en = 1'b0;
    int           rr_m = 0;
    logic         s1_m = 1'b0;
    int           g, cand, lvl_e;
    logic [N_REQ-1:0] exp_rdy;
    logic [W-1:0] item;

    // Outputs are sampled on the falling edge; inputs only change just after rising edges.
    always @(negedge clk) begin
        if (mon_en) begin
            if (areset) begin
                chk_eq("rst_tready", 64'(s_tready), 64'd0);
                exp_q.delete();
                rr_m = 0;
                s1_m = 1'b0;
            end else begin
                lvl_e = exp_q.size() - (s1_m ? 1 : 0);
                chk_eq("level", 64'(fifo_level), 64'(lvl_e));
                chk_eq("m_tvalid", 64'(m_tvalid), 64'(lvl_e > 0));
                g = -1;
                if (exp_q.size() < FIFO_DEPTH) begin
                    for (int i = 0; i < N_REQ; i++) begin
                        cand = (rr_m + i) % N_REQ;
                        if (g < 0 && s_tvalid[cand]) g = cand;
                    end
                end
                exp_rdy = '0;
                if (g >= 0) exp_rdy[g] = 1'b1;
                chk_eq("s_tready", 64'(s_tready), 64'(exp_rdy));
                if (lvl_e > 0 && m_tready) begin
                    item = exp_q.pop_front();
                    chk_eq("out", 64'({m_tuser, m_tdata}), 64'(item));
                end
                if (g >= 0) begin
                    exp_q.push_back({2'(g), ref_f32(s_tdata[g*32 +: 32])});
                    rr_m = (g + 1) % N_REQ;
                end
                s1_m = (g >= 0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        s_tvalid = '0;
        areset   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        areset = 1'b0;
    endtask

    // Present one word on a source until it is accepted; returns just after the accepting edge.
    task automatic send(input int src, input logic [31:0] d);
        logic got;
        got = 1'b0;
        @(posedge clk); #1;
        s_tdata[src*32 +: 32] = d;
        s_tvalid[src]         = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (s_tready[src]) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        s_tvalid[src] = 1'b0;
        if (!got) chk_eq("send_timeout", 64'd0, 64'd1);
    endtask

    logic [31:0] t1_in  [5] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 32'h0100_0001};
    logic [31:0] t1_exp [5] = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 32'hCF00_0000, 32'h4B80_0000};
    logic [3:0]  t4_exp [3] = '{4'b1000, 4'b0010, 4'b1000};

    initial begin
        int acc;
        logic seen;
        areset   = 1'b1;
        s_tvalid = '1;
        s_tdata  = '0;
        m_tready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(negedge clk);
        chk_eq("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk_eq("rst_m_tdata", 64'(m_tdata), 64'd0);
        chk_eq("rst_m_tuser", 64'(m_tuser), 64'd0);
        chk_eq("rst_level", 64'(fifo_level), 64'd0);
        @(posedge clk); #1;
        s_tvalid = '0;
        areset   = 1'b0;

        // 1: single source, fixed vectors, 2-cycle latency
        m_tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(0, t1_in[i]);
            @(negedge clk);
            chk_eq("t1_lat_lo", 64'(m_tvalid), 64'd0);
            @(negedge clk);
            chk_eq("t1_lat_hi", 64'(m_tvalid), 64'd1);
            chk_eq("t1_data", 64'(m_tdata), 64'(t1_exp[i]));
            chk_eq("t1_tuser", 64'(m_tuser), 64'd0);
        end

        // 2: all valid, consumer ready -> 0,1,2,3,0,...
        do_reset();
        m_tready = 1'b1;
        s_tvalid = '1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk_eq("t2_grant", 64'(s_tready), 64'(4'b0001 << (i % 4)));
        end
        @(posedge clk); #1;
        s_tvalid = '0;

        // 3: consumer stalled -> exactly FIFO_DEPTH accepts, stable head, then release
        do_reset();
        m_tready = 1'b0;
        s_tvalid = '1;
        acc = 0;
        repeat (8) begin
            @(negedge clk);
            acc += $countones(s_tready);
        end
        chk_eq("t3_accepts", 64'(acc), 64'(FIFO_DEPTH));
        repeat (3) begin
            @(posedge clk); #1;
            item = exp_q[0];
            chk_eq("t3_level", 64'(fifo_level), 64'(FIFO_DEPTH));
            chk_eq("t3_stall_data", 64'(m_tdata), 64'(item[31:0]));
        end
        m_tready = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (s_tready != '0) begin
                seen = 1'b1;
                break;
            end
        end
        chk_eq("t3_resume", 64'(seen), 64'd1);
        @(posedge clk); #1;
        s_tvalid = '0;

        // 4: sources 1 and 3 with rr_ptr at 2 -> 3,1,3
        do_reset();
        m_tready = 1'b1;
        send(1, 32'd77);
        s_tvalid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_eq("t4_grant", 64'(s_tready), 64'(t4_exp[i]));
        end
        @(posedge clk); #1;
        s_tvalid = '0;

        // 5: reset with S1 busy and 3 FIFO entries
        do_reset();
        m_tready = 1'b0;
        s_tvalid = '1;
        acc = 0;
        for (int t = 0; t < 20 && acc < 4; t++) begin
            @(negedge clk);
            acc += $countones(s_tready);
        end
        @(posedge clk); #1;
        chk_eq("t5_pre_level", 64'(fifo_level), 64'd3);
        areset   = 1'b1;
        m_tready = 1'b1;
        @(negedge clk);
        chk_eq("t5_rst_tready", 64'(s_tready), 64'd0);
        @(posedge clk); #1;
        chk_eq("t5_tvalid", 64'(m_tvalid), 64'd0);
        chk_eq("t5_level", 64'(fifo_level), 64'd0);
        @(posedge clk); #1;
        areset = 1'b0;
        @(negedge clk);
        chk_eq("t5_first", 64'(s_tready), 64'd1);
        @(posedge clk); #1;
        s_tvalid = '0;

        // 6: random traffic against the scoreboard
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk); #1;
            s_tvalid = 4'($urandom_range(0, 15));
            for (int i = 0; i < N_REQ; i++) begin
                case ($urandom_range(0, 7))
                    0:       s_tdata[i*32 +: 32] = 32'h0000_0000;
                    1:       s_tdata[i*32 +: 32] = 32'h8000_0000;
                    2:       s_tdata[i*32 +: 32] = 32'h7FFF_FFFF;
                    3:       s_tdata[i*32 +: 32] = 32'hFFFF_FFFF;
                    default: s_tdata[i*32 +: 32] = $urandom;
                endcase
            end
            if (c < 5000) m_tready = ($urandom_range(0, 3) != 0);
            else          m_tready = ($urandom_range(0, 3) == 0);
        end
        @(posedge clk); #1;
        s_tvalid = '0;
        m_tready = 1'b1;
        for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clk);
        chk_eq("t6_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
